// File: rtl/vga_state_fetch_pkg.sv
// Shared constants and FSM encoding for the per-frame game-state snapshot fetcher.
// The base address must agree with the assembler/memory map.
package vga_state_fetch_pkg;

  localparam int unsigned DEF_BOARD_WORDS = 7;
  localparam int unsigned DEF_ADDR_W      = 16;
  localparam int unsigned DATA_W          = 16;
  localparam logic [15:0] DEF_BASE_ADDR   = 16'h0F00;

  localparam int unsigned IDX_COLNO   = DEF_BOARD_WORDS;
  localparam int unsigned IDX_PLAYER  = DEF_BOARD_WORDS + 1;
  localparam int unsigned FETCH_WORDS = DEF_BOARD_WORDS + 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_COMMIT
  } state_e;

endpackage

// File: rtl/vga_state_fetch_if.sv
// Read-only port B of the shared data memory, as seen by the snapshot fetcher.
interface vga_state_fetch_if
  import vga_state_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) ();

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  modport master (output mem_rd_en, output mem_addr, input  mem_rdata);
  modport slave  (input  mem_rd_en, input  mem_addr, output mem_rdata);

endinterface

// File: rtl/vga_state_fetch_state_shadow_regs.sv
// Back/front game-state buffers: indexed fill of the back buffer, one-cycle
// commit into the front buffer, and the registered renderer lookup mux.
module vga_state_fetch_state_shadow_regs
  import vga_state_fetch_pkg::*;
#(
  parameter int unsigned BOARD_WORDS = DEF_BOARD_WORDS,
  parameter int unsigned FETCH_W     = BOARD_WORDS + 2,
  parameter int unsigned IDX_W       = $clog2(FETCH_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              commit_i,
  input  logic [2:0]        lookup_sel_i,
  output logic [DATA_W-1:0] game_board_o,
  output logic [DATA_W-1:0] column_no_o,
  output logic [DATA_W-1:0] player_o
);

  logic [DATA_W-1:0] back_q  [FETCH_W];
  logic [DATA_W-1:0] front_q [FETCH_W];
  logic [DATA_W-1:0] game_board_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < FETCH_W; i++) begin
        back_q[i]  <= '0;
        front_q[i] <= '0;
      end
      game_board_q <= '0;
    end else begin
      if (wr_en_i) begin
        back_q[wr_idx_i] <= wr_data_i;
      end
      // The last word lands on the commit edge, so it bypasses the back buffer.
      if (commit_i) begin
        for (int unsigned i = 0; i < FETCH_W; i++) begin
          front_q[i] <= (wr_en_i && wr_idx_i == IDX_W'(i)) ? wr_data_i : back_q[i];
        end
      end
      if (IDX_W'(lookup_sel_i) < IDX_W'(BOARD_WORDS)) begin
        game_board_q <= front_q[IDX_W'(lookup_sel_i)];
      end else begin
        game_board_q <= '0;
      end
    end
  end

  assign game_board_o = game_board_q;
  assign column_no_o  = front_q[IDX_W'(BOARD_WORDS)];
  assign player_o     = front_q[IDX_W'(BOARD_WORDS + 1)];

endmodule

// File: rtl/vga_state_fetch.sv
// Snapshots board/column_no/player from memory on each vsync falling edge and
// commits them atomically so the renderer always sees a consistent frame.
module vga_state_fetch
  import vga_state_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W      = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(DEF_BASE_ADDR),
  parameter int unsigned       BOARD_WORDS = DEF_BOARD_WORDS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 vsync,
  input  logic                 hold,
  input  logic [11:0]          vga_lookup,
  vga_state_fetch_if.master    mem,
  output logic [DATA_W-1:0]    game_board,
  output logic [DATA_W-1:0]    column_no,
  output logic [DATA_W-1:0]    player,
  output logic                 snap_valid,
  output logic                 frame_done
);

  localparam int unsigned      FETCH_W  = BOARD_WORDS + 2;
  localparam int unsigned      IDX_W    = $clog2(FETCH_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FETCH_W - 1);

  state_e            state_q;
  logic              vsync_q;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  idx_d_q;
  logic              rd_en_q;
  logic              rd_d_q;
  logic [ADDR_W-1:0] addr_q;
  logic              frame_done_q;
  logic              snap_valid_q;
  logic              start;
  logic [8:0]        unused_lookup_hi;

  assign start            = vsync_q & ~vsync;
  assign unused_lookup_hi = vga_lookup[11:3];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      vsync_q      <= 1'b1;
      idx_q        <= '0;
      idx_d_q      <= '0;
      rd_en_q      <= 1'b0;
      rd_d_q       <= 1'b0;
      addr_q       <= '0;
      frame_done_q <= 1'b0;
      snap_valid_q <= 1'b0;
    end else begin
      vsync_q      <= vsync;
      rd_d_q       <= rd_en_q;
      idx_d_q      <= idx_q;
      frame_done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start && !hold) begin
            state_q <= ST_READ;
            idx_q   <= '0;
            rd_en_q <= 1'b1;
            addr_q  <= BASE_ADDR;
          end
        end
        ST_READ: begin
          if (idx_q == LAST_IDX) begin
            state_q <= ST_DRAIN;
            rd_en_q <= 1'b0;
          end else begin
            idx_q  <= idx_q + IDX_W'(1);
            addr_q <= addr_q + ADDR_W'(1);
          end
        end
        ST_DRAIN: begin
          state_q      <= ST_COMMIT;
          frame_done_q <= 1'b1;
          snap_valid_q <= 1'b1;
        end
        ST_COMMIT: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  vga_state_fetch_state_shadow_regs #(
    .BOARD_WORDS (BOARD_WORDS),
    .FETCH_W     (FETCH_W),
    .IDX_W       (IDX_W)
  ) u_shadow (
    .clk          (clk),
    .rst          (rst),
    .wr_en_i      (rd_d_q),
    .wr_idx_i     (idx_d_q),
    .wr_data_i    (mem.mem_rdata),
    .commit_i     (state_q == ST_DRAIN),
    .lookup_sel_i (vga_lookup[2:0]),
    .game_board_o (game_board),
    .column_no_o  (column_no),
    .player_o     (player)
  );

  assign mem.mem_rd_en = rd_en_q;
  assign mem.mem_addr  = addr_q;
  assign snap_valid    = snap_valid_q;
  assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_vga_state_fetch.sv
// Bench for vga_state_fetch: synchronous memory model plus a frame-level model
// of what the front buffer should hold after each committed snapshot.
module tb_vga_state_fetch;

  localparam logic [15:0] BASE = 16'h0F00;
  localparam int unsigned NW   = 9;

  logic        clk = 1'b0;
  logic        rst;
  logic        vsync;
  logic        hold;
  logic [11:0] vga_lookup;
  logic [15:0] game_board;
  logic [15:0] column_no;
  logic [15:0] player;
  logic        snap_valid;
  logic        frame_done;

  vga_state_fetch_if #(.ADDR_W(16)) bus ();

  vga_state_fetch #(
    .ADDR_W      (16),
    .BASE_ADDR   (BASE),
    .BOARD_WORDS (7)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .vsync      (vsync),
    .hold       (hold),
    .vga_lookup (vga_lookup),
    .mem        (bus),
    .game_board (game_board),
    .column_no  (column_no),
    .player     (player),
    .snap_valid (snap_valid),
    .frame_done (frame_done)
  );

  always #10 clk = ~clk;

  logic [15:0] ram [65536];
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rdata <= ram[bus.mem_addr];
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] rd_q[$];
  int unsigned fd_q[$];
  always @(negedge clk) begin
    if (bus.mem_rd_en) rd_q.push_back(bus.mem_addr);
    if (frame_done)    fd_q.push_back(cyc);
  end

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [15:0] exp_front [NW];
  logic        exp_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_column_no"},  column_no,  exp_front[7]);
    chk({tag, "_player"},     player,     exp_front[8]);
    chk({tag, "_snap_valid"}, snap_valid, exp_valid);
    chk({tag, "_frame_done"}, frame_done, 1'b0);
  endtask

  task automatic lookup(input logic [11:0] v);
    logic [15:0] exp;
    @(posedge clk); #1 vga_lookup = v;
    @(posedge clk);
    @(negedge clk);
    exp = (v[2:0] < 3'd7) ? exp_front[v[2:0]] : 16'h0000;
    chk("game_board", game_board, exp);
  endtask

  task automatic run_frame(input bit hold_v, input bit glitch);
    logic [15:0] snap [NW];
    int unsigned t0;
    for (int i = 0; i < NW; i++) snap[i] = ram[BASE + 16'(i)];
    rd_q.delete();
    fd_q.delete();
    @(posedge clk); #1;
    vsync = 1'b0;
    hold  = hold_v;
    t0    = cyc;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (c == 1) hold = 1'($urandom_range(0, 1));
      if (glitch && c == 4) vsync = 1'b1;
      if (glitch && c == 5) vsync = 1'b0;
    end
    @(negedge clk);
    vsync = 1'b1;
    hold  = 1'b0;
    chk("rd_count", rd_q.size(), hold_v ? 0 : NW);
    for (int i = 0; i < rd_q.size(); i++) chk("rd_addr", rd_q[i], BASE + 16'(i));
    chk("fd_count", fd_q.size(), hold_v ? 0 : 1);
    if (fd_q.size() > 0) chk("fd_latency", fd_q[0] - t0, 11);
    if (!hold_v) begin
      for (int i = 0; i < NW; i++) exp_front[i] = snap[i];
      exp_valid = 1'b1;
    end
    check_outputs("frame");
  endtask

  initial begin
    for (int i = 0; i < NW; i++) exp_front[i] = '0;
    exp_valid  = 1'b0;
    rst        = 1'b0;
    vsync      = 1'b1;
    hold       = 1'b0;
    vga_lookup = '0;
    for (int i = 0; i < NW; i++) ram[BASE + 16'(i)] = 16'h1000 + 16'(i);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Reset then idle.
    @(negedge clk);
    chk("rst_game_board", game_board, 16'h0000);
    check_outputs("rst");
    rd_q.delete();
    fd_q.delete();
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("idle_rd_count", rd_q.size(), 0);
    chk("idle_fd_count", fd_q.size(), 0);

    // Reset on the 4th READ cycle of the first fetch.
    @(posedge clk); #1 vsync = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    fd_q.delete();
    @(negedge clk);
    chk("midrst_rd_en", bus.mem_rd_en, 1'b0);
    chk("midrst_game_board", game_board, 16'h0000);
    check_outputs("midrst");
    vsync = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("midrst_fd_count", fd_q.size(), 0);

    // Basic snapshot and lookup range.
    run_frame(1'b0, 1'b0);
    chk("basic_column_no", column_no, 16'h1007);
    chk("basic_player", player, 16'h1008);
    lookup(12'h003);
    lookup(12'hFF2);
    lookup(12'h007);
    for (int s = 0; s < 8; s++) lookup({9'($urandom), 3'(s)});

    // Tear-free: memory change is invisible until the next commit.
    ram[BASE + 16'd7] = 16'h0004;
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("tear_column_no_held", column_no, 16'h1007);
    run_frame(1'b0, 1'b1);
    chk("tear_column_no_new", column_no, 16'h0004);

    // Hold skips one snapshot; the following edge fetches normally.
    for (int i = 0; i < NW; i++) ram[BASE + 16'(i)] = 16'($urandom);
    run_frame(1'b1, 1'b0);
    lookup({9'($urandom), 3'($urandom_range(0, 6))});
    run_frame(1'b0, 1'b0);

    // Randomized frames.
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < NW; i++) ram[BASE + 16'(i)] = 16'($urandom);
      run_frame(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
      repeat (3) lookup(12'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
